stepper_multi_controller: RTL and testbench
===========================================

Name: stepper_multi_controller

Overview:
- Parametrised N-channel stepper-motor pulse generator. It replaces the single-channel fixed-step controller.
- Per channel it adds: direction, start/busy/done handshake, abort, a minimum direction-setup time, and a signed position counter.
- It sits between processor-visible command registers (MMIO decode, built separately) and the motor-driver STEP/DIR pins on the drawing robot.
- Each channel runs independently from one shared clock.

Parameters:
NUM_CH, 2, number of independent motor channels (1..8)
CNT_W, 32, width of the step-count and period fields
POS_W, 32, width of the signed position counter per channel
PULSE_W, 2, STEP high time in clock cycles (>=1)
DIR_SETUP, 1, cycles DIR is held stable before the first STEP rise (>=1)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  NUM_CH  per-channel command strobe, sampled only in IDLE
dir_in  in  NUM_CH  requested direction (1 = positive)
num_steps  in  NUM_CH*CNT_W  step count, channel i at [i*CNT_W +: CNT_W]
step_period  in  NUM_CH*CNT_W  cycles between consecutive STEP rising edges
abort  in  NUM_CH  stop channel early
zero_pos  in  NUM_CH  synchronous clear of position
step_out  out  NUM_CH  STEP pulse to driver
dir_out  out  NUM_CH  DIR level to driver
busy  out  NUM_CH  channel executing a move
done  out  NUM_CH  1-cycle pulse at move end (normal, zero-length or aborted)
aborted  out  NUM_CH  1-cycle pulse coincident with done when the move was aborted
position  out  NUM_CH*POS_W  signed step position per channel

Behaviour:
- Reset (reset low, asynchronous): all channels go to IDLE; step_out, dir_out, busy, done and aborted are 0; position is 0; latched command fields are 0. Deassertion is synchronous to clock in use.
- Per-channel FSM: IDLE -> SETUP -> HI -> LO -> (HI | FINISH) -> IDLE.
- IDLE, start=1 at edge T:
  - latch num_steps, step_period and dir_in;
  - dir_out takes dir_in from T+1;
  - if num_steps==0, go to FINISH: done pulses at T+1, no STEP is issued, busy stays 0;
  - otherwise busy=1 from T+1 and the FSM enters SETUP.
- SETUP: lasts DIR_SETUP cycles. step_out first rises at T+1+DIR_SETUP.
- HI: step_out=1 for PULSE_W cycles. Position changes by +1 (dir=1) or -1 (dir=0) on the cycle step_out rises.
- LO: step_out=0 for (eff_period - PULSE_W) cycles.
  - eff_period = max(step_period, PULSE_W+1), so LO is always at least 1 cycle.
  - The STEP rise-to-rise spacing is exactly eff_period.
- A remaining-step counter decrements on each HI entry. After the LO phase of the last step, go to FINISH.
- FINISH (1 cycle): done=1 and busy=0 in the same cycle, then IDLE. The next start is accepted in that FINISH cycle's following edge at the earliest.
- Latency for a full move: the done pulse occurs at cycle T+1+DIR_SETUP+num_steps*eff_period.
- start while busy: ignored. Latched fields, dir_out and the step sequence are unaffected.
- abort:
  - in SETUP or LO: FINISH next cycle, with aborted=1 alongside done;
  - in HI: the current pulse completes its full PULSE_W width, then FINISH with aborted=1. STEP pulses are never truncated.
  - abort in IDLE is ignored.
- zero_pos:
  - sets position to 0 next cycle in any state;
  - if it coincides with a step increment, clear wins and the result is 0.
- Position wraps modulo 2^POS_W, two's complement. No saturation.
- dir_out changes only on command acceptance, never while busy.
- Channels share no state. Simultaneous starts on all channels are all accepted.
- Reset mid-move: step_out drops immediately (asynchronous); position clears; no done pulse is issued.
- Counters are CNT_W wide. num_steps up to 2^CNT_W-1 is supported without overflow.

Decomposition:
- Shared package stepper_pkg holds:
  - the FSM state enum (IDLE, SETUP, HI, LO, FINISH);
  - the default PULSE_W and DIR_SETUP constants;
  - a slice helper for packed per-channel buses.
- One sub-module, stepper_channel, implements a single-channel FSM, counters and position register.
- The top level is a generate loop of NUM_CH instances plus bus packing.

Test Plan:
1. NUM_CH=2, PULSE_W=2, DIR_SETUP=1. ch0 start at edge 10, num_steps=3, period=5, dir=1 -> busy at 11; step_out rises at 12, 17, 22 (each high 2 cycles); done at 27; position0=3.
2. ch1 dir=0, num_steps=4, period=1 (clamped to 3) -> rises 3 cycles apart; position1=-4; done 1+1+12 cycles after start.
3. num_steps=0 -> done pulse the next cycle; busy never asserts; no step_out; position unchanged.
4. abort during the 2nd HI cycle of step 2 (period=10, num_steps=5) -> the pulse completes its full width; done and aborted pulse together after HI ends; position=2. A start while busy in the same run is ignored.
5. position=5, then zero_pos asserted on the same cycle as a step rise -> position=0. Separately, position=-1 with dir=1 and 1 step -> position=0 (wrap check with POS_W=8 from 127 -> -128).
6. Assert reset low mid-HI on both channels -> step_out, busy and position are 0 asynchronously; no done. After release, a new start executes normally.

Source files
------------

// File: rtl/stepper_pkg.sv
// Shared definitions for the multi-channel stepper pulse generator.
package stepper_pkg;

   // Per-channel FSM encoding
   localparam logic [2:0] StIdle   = 3'd0;
   localparam logic [2:0] StSetup  = 3'd1;
   localparam logic [2:0] StHi     = 3'd2;
   localparam logic [2:0] StLo     = 3'd3;
   localparam logic [2:0] StFinish = 3'd4;

   localparam int unsigned DefPulseW   = 2;
   localparam int unsigned DefDirSetup = 1;

   // LSB index of channel ch inside a packed bus of w-bit fields
   function automatic int unsigned slice_lsb(input int unsigned ch, input int unsigned w);
      return ch * w;
   endfunction

endpackage

// File: rtl/stepper_channel.sv
// Single stepper channel: command latch, step timing FSM and signed position counter.
module stepper_channel
   import stepper_pkg::*;
#(
   parameter int unsigned CNT_W     = 32,
   parameter int unsigned POS_W     = 32,
   parameter int unsigned PULSE_W   = DefPulseW,
   parameter int unsigned DIR_SETUP = DefDirSetup
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic             dir_i,
   input  logic [CNT_W-1:0] num_steps_i,
   input  logic [CNT_W-1:0] step_period_i,
   input  logic             abort_i,
   input  logic             zero_pos_i,
   output logic             step_o,
   output logic             dir_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             aborted_o,
   output logic [POS_W-1:0] position_o
);

   localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);
   localparam logic [CNT_W-1:0] PulseW    = CNT_W'(PULSE_W);
   localparam logic [CNT_W-1:0] MinPeriod = CNT_W'(PULSE_W + 1);
   localparam logic [CNT_W-1:0] SetupLd   = CNT_W'(DIR_SETUP - 1);
   localparam logic [CNT_W-1:0] HiLd      = CNT_W'(PULSE_W - 1);
   localparam logic [POS_W-1:0] PosOne    = POS_W'(1);

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] rem_q, rem_d;       // steps still to be issued
   logic [CNT_W-1:0] ph_q, ph_d;         // cycles left in current phase, minus one
   logic [CNT_W-1:0] lo_len_q, lo_len_d; // LO phase length, always >= 1
   logic             dir_q, dir_d;
   logic             ab_pend_q, ab_pend_d; // abort seen during HI, honoured at HI end
   logic             ab_q, ab_d;           // current FINISH was caused by abort
   logic [POS_W-1:0] pos_q, pos_d;
   logic             step_rise;
   logic [CNT_W-1:0] eff_period;

   // Clamp the period so the LO phase is never empty
   always_comb begin
      eff_period = (step_period_i < MinPeriod) ? MinPeriod : step_period_i;
   end

   // Next-state logic for the step sequencer
   always_comb begin
      state_d   = state_q;
      rem_d     = rem_q;
      ph_d      = ph_q;
      lo_len_d  = lo_len_q;
      dir_d     = dir_q;
      ab_pend_d = ab_pend_q;
      ab_d      = ab_q;
      step_rise = 1'b0;
      case (state_q)
         StIdle: begin
            ab_d      = 1'b0;
            ab_pend_d = 1'b0;
            if (start_i) begin
               dir_d    = dir_i;
               rem_d    = num_steps_i;
               lo_len_d = eff_period - PulseW;
               ph_d     = SetupLd;
               state_d  = (num_steps_i == '0) ? StFinish : StSetup;
            end
         end
         StSetup: begin
            if (abort_i) begin
               ab_d    = 1'b1;
               state_d = StFinish;
            end else if (ph_q == '0) begin
               state_d   = StHi;
               ph_d      = HiLd;
               rem_d     = rem_q - CntOne;
               step_rise = 1'b1;
            end else begin
               ph_d = ph_q - CntOne;
            end
         end
         StHi: begin
            if (abort_i) begin
               ab_pend_d = 1'b1;
            end
            if (ph_q == '0) begin
               if (abort_i || ab_pend_q) begin
                  ab_d    = 1'b1;
                  state_d = StFinish;
               end else begin
                  state_d = StLo;
                  ph_d    = lo_len_q - CntOne;
               end
            end else begin
               ph_d = ph_q - CntOne;
            end
         end
         StLo: begin
            if (abort_i) begin
               ab_d    = 1'b1;
               state_d = StFinish;
            end else if (ph_q == '0) begin
               if (rem_q == '0) begin
                  state_d = StFinish;
               end else begin
                  state_d   = StHi;
                  ph_d      = HiLd;
                  rem_d     = rem_q - CntOne;
                  step_rise = 1'b1;
               end
            end else begin
               ph_d = ph_q - CntOne;
            end
         end
         StFinish: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Position: clear has priority over a coincident step
   always_comb begin
      pos_d = pos_q;
      if (zero_pos_i) begin
         pos_d = '0;
      end else if (step_rise) begin
         pos_d = dir_q ? (pos_q + PosOne) : (pos_q - PosOne);
      end
   end

   // State registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= StIdle;
         rem_q     <= '0;
         ph_q      <= '0;
         lo_len_q  <= '0;
         dir_q     <= 1'b0;
         ab_pend_q <= 1'b0;
         ab_q      <= 1'b0;
         pos_q     <= '0;
      end else begin
         state_q   <= state_d;
         rem_q     <= rem_d;
         ph_q      <= ph_d;
         lo_len_q  <= lo_len_d;
         dir_q     <= dir_d;
         ab_pend_q <= ab_pend_d;
         ab_q      <= ab_d;
         pos_q     <= pos_d;
      end
   end

   // Outputs decode directly from registered state
   always_comb begin
      step_o     = (state_q == StHi);
      busy_o     = (state_q == StSetup) || (state_q == StHi) || (state_q == StLo);
      done_o     = (state_q == StFinish);
      aborted_o  = (state_q == StFinish) && ab_q;
      dir_o      = dir_q;
      position_o = pos_q;
   end

endmodule

// File: rtl/stepper_multi_controller.sv
// N-channel stepper pulse generator: independent channels on one clock, packed buses.
module stepper_multi_controller
   import stepper_pkg::*;
#(
   parameter int unsigned NUM_CH    = 2,
   parameter int unsigned CNT_W     = 32,
   parameter int unsigned POS_W     = 32,
   parameter int unsigned PULSE_W   = DefPulseW,
   parameter int unsigned DIR_SETUP = DefDirSetup
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [NUM_CH-1:0]       start,
   input  logic [NUM_CH-1:0]       dir_in,
   input  logic [NUM_CH*CNT_W-1:0] num_steps,
   input  logic [NUM_CH*CNT_W-1:0] step_period,
   input  logic [NUM_CH-1:0]       abort,
   input  logic [NUM_CH-1:0]       zero_pos,
   output logic [NUM_CH-1:0]       step_out,
   output logic [NUM_CH-1:0]       dir_out,
   output logic [NUM_CH-1:0]       busy,
   output logic [NUM_CH-1:0]       done,
   output logic [NUM_CH-1:0]       aborted,
   output logic [NUM_CH*POS_W-1:0] position
);

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      localparam int unsigned CLsb = slice_lsb(g, CNT_W);
      localparam int unsigned PLsb = slice_lsb(g, POS_W);

      stepper_channel #(
         .CNT_W     (CNT_W),
         .POS_W     (POS_W),
         .PULSE_W   (PULSE_W),
         .DIR_SETUP (DIR_SETUP)
      ) u_ch (
         .clk_i         (clock),
         .rst_ni        (reset),
         .start_i       (start[g]),
         .dir_i         (dir_in[g]),
         .num_steps_i   (num_steps[CLsb +: CNT_W]),
         .step_period_i (step_period[CLsb +: CNT_W]),
         .abort_i       (abort[g]),
         .zero_pos_i    (zero_pos[g]),
         .step_o        (step_out[g]),
         .dir_o         (dir_out[g]),
         .busy_o        (busy[g]),
         .done_o        (done[g]),
         .aborted_o     (aborted[g]),
         .position_o    (position[PLsb +: POS_W])
      );
   end

endmodule

// File: tb/tb_stepper_multi_controller.sv
// Directed bench for stepper_multi_controller (2-channel 32-bit DUT plus 1-channel 8-bit wrap DUT).
module tb_stepper_multi_controller;

   localparam int PW = 2;
   localparam int DS = 1;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [1:0]  start, dir_in, abort, zero_pos;
   logic [63:0] num_steps, step_period;
   logic [1:0]  step_out, dir_out, busy, done, aborted;
   logic [63:0] position;

   logic        w_start, w_dir_in, w_abort, w_zero_pos;
   logic [31:0] w_num_steps, w_step_period;
   logic        w_step_out, w_dir_out, w_busy, w_done, w_aborted;
   logic [7:0]  w_position;

   int tests = 0;
   int fails = 0;

   stepper_multi_controller #(
      .NUM_CH(2), .CNT_W(32), .POS_W(32), .PULSE_W(PW), .DIR_SETUP(DS)
   ) u_dut (
      .clock(clock), .reset(reset_n), .start(start), .dir_in(dir_in),
      .num_steps(num_steps), .step_period(step_period), .abort(abort),
      .zero_pos(zero_pos), .step_out(step_out), .dir_out(dir_out), .busy(busy),
      .done(done), .aborted(aborted), .position(position)
   );

   stepper_multi_controller #(
      .NUM_CH(1), .CNT_W(32), .POS_W(8), .PULSE_W(PW), .DIR_SETUP(DS)
   ) u_wrap (
      .clock(clock), .reset(reset_n), .start(w_start), .dir_in(w_dir_in),
      .num_steps(w_num_steps), .step_period(w_step_period), .abort(w_abort),
      .zero_pos(w_zero_pos), .step_out(w_step_out), .dir_out(w_dir_out), .busy(w_busy),
      .done(w_done), .aborted(w_aborted), .position(w_position)
   );

   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Expected behaviour as a function of j = cycles since the accepting edge (j=1 first)
   function automatic logic f_step(input int j, input int n, input int eff);
      int k;
      k = j - 1 - DS;
      if (k < 0) return 1'b0;
      if (k / eff >= n) return 1'b0;
      return (k % eff) < PW;
   endfunction

   function automatic logic f_busy(input int j, input int n, input int eff);
      if (n == 0) return 1'b0;
      return (j >= 1) && (j < 1 + DS + n * eff);
   endfunction

   function automatic logic f_done(input int j, input int n, input int eff);
      if (n == 0) return j == 1;
      return j == 1 + DS + n * eff;
   endfunction

   // Advance until the selected done is seen or the budget runs out (no comparison here)
   task automatic wait_done(input bit wide, input int budget, output bit seen);
      int i;
      seen = 1'b0;
      i = 0;
      while (!seen && i < budget) begin
         if ((wide ? w_done : done[0]) === 1'b1) seen = 1'b1;
         else tick();
         i++;
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      start = '0; dir_in = '0; abort = '0; zero_pos = '0;
      num_steps = '0; step_period = '0;
      w_start = 1'b0; w_dir_in = 1'b0; w_abort = 1'b0; w_zero_pos = 1'b0;
      w_num_steps = '0; w_step_period = '0;
      #1;
      tests++;
      if ({step_out, dir_out, busy, done, aborted} !== 10'b0) begin
         $display("FAIL reset_outputs: got %b want 0", {step_out, dir_out, busy, done, aborted});
         fails++;
      end
      tests++;
      if (position !== 64'd0 || w_position !== 8'd0) begin
         $display("FAIL reset_position: got %h/%h want 0", position, w_position);
         fails++;
      end
      tick(); tick();
      reset_n = 1'b1;
      tick(); tick();
      tests++;
      if ({step_out, busy, done, aborted, w_busy, w_done} !== 10'b0) begin
         $display("FAIL post_reset_idle: got %b want 0",
                  {step_out, busy, done, aborted, w_busy, w_done});
         fails++;
      end
   endtask

   // ch0: 3 steps period 5 dir+ ; ch1: 4 steps period 1 (clamped to 3) dir- ; started together
   task automatic test_basic_moves();
      logic [1:0] e_step, e_busy, e_done;
      start = 2'b11; dir_in = 2'b01;
      num_steps = {32'd4, 32'd3};
      step_period = {32'd1, 32'd5};
      tick();
      start = 2'b00;
      for (int j = 1; j <= 19; j++) begin
         e_step = {f_step(j, 4, 3), f_step(j, 3, 5)};
         e_busy = {f_busy(j, 4, 3), f_busy(j, 3, 5)};
         e_done = {f_done(j, 4, 3), f_done(j, 3, 5)};
         tests++;
         if (step_out !== e_step) begin
            $display("FAIL basic_step j=%0d: got %b want %b", j, step_out, e_step);
            fails++;
         end
         tests++;
         if (busy !== e_busy) begin
            $display("FAIL basic_busy j=%0d: got %b want %b", j, busy, e_busy);
            fails++;
         end
         tests++;
         if (done !== e_done || aborted !== 2'b00) begin
            $display("FAIL basic_done j=%0d: got %b/%b want %b/00", j, done, aborted, e_done);
            fails++;
         end
         tests++;
         if (dir_out !== 2'b01) begin
            $display("FAIL basic_dir j=%0d: got %b want 01", j, dir_out);
            fails++;
         end
         tick();
      end
      tests++;
      if (position[31:0] !== 32'd3) begin
         $display("FAIL basic_pos0: got %0d want 3", $signed(position[31:0]));
         fails++;
      end
      tests++;
      if (position[63:32] !== 32'hFFFF_FFFC) begin
         $display("FAIL basic_pos1: got %0d want -4", $signed(position[63:32]));
         fails++;
      end
   endtask

   task automatic test_zero_length();
      start = 2'b01; dir_in = 2'b01; num_steps = 64'd0; step_period = {32'd0, 32'd5};
      tick();
      start = 2'b00;
      tests++;
      if (done[0] !== 1'b1 || busy[0] !== 1'b0 || step_out[0] !== 1'b0) begin
         $display("FAIL zero_len_first: done/busy/step got %b%b%b want 100",
                  done[0], busy[0], step_out[0]);
         fails++;
      end
      for (int j = 2; j <= 5; j++) begin
         tick();
         tests++;
         if (done[0] !== 1'b0 || busy[0] !== 1'b0 || step_out[0] !== 1'b0) begin
            $display("FAIL zero_len_after j=%0d: done/busy/step got %b%b%b want 000",
                     j, done[0], busy[0], step_out[0]);
            fails++;
         end
      end
      tests++;
      if (position[31:0] !== 32'd3) begin
         $display("FAIL zero_len_pos: got %0d want 3", $signed(position[31:0]));
         fails++;
      end
   endtask

   // 5 steps period 10; a conflicting start while busy; abort on the 2nd HI cycle of step 2
   task automatic test_abort_and_ignored_start();
      logic e_step;
      zero_pos = 2'b01;
      tick();
      zero_pos = 2'b00;
      tests++;
      if (position[31:0] !== 32'd0) begin
         $display("FAIL abort_prezero: got %0d want 0", $signed(position[31:0]));
         fails++;
      end
      start = 2'b01; dir_in = 2'b01; num_steps = {32'd0, 32'd5}; step_period = {32'd0, 32'd10};
      tick();
      start = 2'b00;
      for (int j = 1; j <= 16; j++) begin
         e_step = (j <= 13) ? f_step(j, 5, 10) : 1'b0;
         tests++;
         if (step_out[0] !== e_step) begin
            $display("FAIL abort_step j=%0d: got %b want %b", j, step_out[0], e_step);
            fails++;
         end
         tests++;
         if (done[0] !== (j == 14) || aborted[0] !== (j == 14)) begin
            $display("FAIL abort_done j=%0d: done/aborted got %b%b want %b%b",
                     j, done[0], aborted[0], j == 14, j == 14);
            fails++;
         end
         tests++;
         if (busy[0] !== (j <= 13) || dir_out[0] !== 1'b1) begin
            $display("FAIL abort_busy_dir j=%0d: busy/dir got %b%b want %b1",
                     j, busy[0], dir_out[0], j <= 13);
            fails++;
         end
         if (j == 4) begin
            start = 2'b01; dir_in = 2'b00; num_steps = {32'd0, 32'd1};
         end else if (j == 5) begin
            start = 2'b00;
         end
         if (j == 13) abort = 2'b01;
         else abort = 2'b00;
         tick();
      end
      tests++;
      if (position[31:0] !== 32'd2) begin
         $display("FAIL abort_pos: got %0d want 2", $signed(position[31:0]));
         fails++;
      end
   endtask

   task automatic test_zero_pos_and_wrap();
      bit seen;
      zero_pos = 2'b01;
      tick();
      zero_pos = 2'b00;
      start = 2'b01; dir_in = 2'b01; num_steps = {32'd0, 32'd5}; step_period = {32'd0, 32'd3};
      tick();
      start = 2'b00;
      wait_done(1'b0, 40, seen);
      tests++;
      if (!seen || position[31:0] !== 32'd5) begin
         $display("FAIL zp_five: done_seen=%0d pos=%0d want 1/5", seen, $signed(position[31:0]));
         fails++;
      end
      tick();
      // Clear coincident with the step rise
      start = 2'b01; num_steps = {32'd0, 32'd1};
      tick();
      start = 2'b00;
      zero_pos = 2'b01;
      tick();
      zero_pos = 2'b00;
      tests++;
      if (step_out[0] !== 1'b1 || position[31:0] !== 32'd0) begin
         $display("FAIL zp_coincide: step/pos got %b/%0d want 1/0",
                  step_out[0], $signed(position[31:0]));
         fails++;
      end
      wait_done(1'b0, 20, seen);
      tick();
      start = 2'b01; dir_in = 2'b00;
      tick();
      start = 2'b00;
      wait_done(1'b0, 20, seen);
      tests++;
      if (!seen || position[31:0] !== 32'hFFFF_FFFF) begin
         $display("FAIL zp_minus1: done_seen=%0d pos=%0d want 1/-1", seen, $signed(position[31:0]));
         fails++;
      end
      tick();
      start = 2'b01; dir_in = 2'b01;
      tick();
      start = 2'b00;
      wait_done(1'b0, 20, seen);
      tests++;
      if (!seen || position[31:0] !== 32'd0) begin
         $display("FAIL zp_back0: done_seen=%0d pos=%0d want 1/0", seen, $signed(position[31:0]));
         fails++;
      end
      // 8-bit position: 127 steps then one more wraps to -128
      w_start = 1'b1; w_dir_in = 1'b1; w_num_steps = 32'd127; w_step_period = 32'd3;
      tick();
      w_start = 1'b0;
      wait_done(1'b1, 500, seen);
      tests++;
      if (!seen || w_position !== 8'h7F) begin
         $display("FAIL wrap_127: done_seen=%0d pos=%h want 1/7f", seen, w_position);
         fails++;
      end
      tick();
      w_start = 1'b1; w_num_steps = 32'd1;
      tick();
      w_start = 1'b0;
      wait_done(1'b1, 20, seen);
      tests++;
      if (!seen || w_position !== 8'h80) begin
         $display("FAIL wrap_m128: done_seen=%0d pos=%h want 1/80", seen, w_position);
         fails++;
      end
      tick();
   endtask

   task automatic test_reset_mid_move();
      bit seen;
      start = 2'b11; dir_in = 2'b11;
      num_steps = {32'd10, 32'd10}; step_period = {32'd4, 32'd4};
      tick();
      start = 2'b00;
      tick();
      tests++;
      if (step_out !== 2'b11 || busy !== 2'b11) begin
         $display("FAIL rst_pre_hi: step/busy got %b/%b want 11/11", step_out, busy);
         fails++;
      end
      #2;
      reset_n = 1'b0;
      #1;
      tests++;
      if (step_out !== 2'b00 || busy !== 2'b00 || position !== 64'd0 || done !== 2'b00) begin
         $display("FAIL rst_async: step/busy/done got %b/%b/%b pos=%h want 0",
                  step_out, busy, done, position);
         fails++;
      end
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      tests++;
      if (done !== 2'b00 || aborted !== 2'b00 || busy !== 2'b00 || dir_out !== 2'b00) begin
         $display("FAIL rst_after: done/aborted/busy/dir got %b/%b/%b/%b want 0",
                  done, aborted, busy, dir_out);
         fails++;
      end
      start = 2'b01; dir_in = 2'b01; num_steps = {32'd0, 32'd2}; step_period = {32'd0, 32'd3};
      tick();
      start = 2'b00;
      tests++;
      if (busy !== 2'b01 || dir_out[0] !== 1'b1) begin
         $display("FAIL rst_restart_busy: busy/dir got %b/%b want 01/1", busy, dir_out[0]);
         fails++;
      end
      wait_done(1'b0, 30, seen);
      tests++;
      if (!seen || position[31:0] !== 32'd2 || position[63:32] !== 32'd0) begin
         $display("FAIL rst_restart_pos: done_seen=%0d pos=%h want 1/0000000000000002",
                  seen, position);
         fails++;
      end
   endtask

   initial begin
      test_reset();
      test_basic_moves();
      test_zero_length();
      test_abort_and_ignored_start();
      test_zero_pos_and_wrap();
      test_reset_mid_move();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
